// File: rtl/filt_pkg.sv
// -----------------------------------------------------------------------------
// filt_pkg
// Shared definitions for the box-car averaging filter and its downstream
// decimator: filter-length select codes, the code-to-ratio mapping and the
// decimator state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package filt_pkg;

    // Filter-length select codes (filter length / decimation ratio = 1 << code)
    localparam logic [2:0] FILT_SEL_1  = 3'd0;
    localparam logic [2:0] FILT_SEL_2  = 3'd1;
    localparam logic [2:0] FILT_SEL_4  = 3'd2;
    localparam logic [2:0] FILT_SEL_8  = 3'd3;
    localparam logic [2:0] FILT_SEL_16 = 3'd4;

    typedef enum logic {
        SETTLE = 1'b0,
        RUN    = 1'b1
    } filt_state_e;

    // Decimation ratio for a select code. Codes 5..7 put the upstream filter
    // into delayed passthrough, so every sample is kept.
    function automatic logic [4:0] filt_ratio(input logic [2:0] sel);
        logic [4:0] ratio;
        case (sel)
            FILT_SEL_1:  ratio = 5'd1;
            FILT_SEL_2:  ratio = 5'd2;
            FILT_SEL_4:  ratio = 5'd4;
            FILT_SEL_8:  ratio = 5'd8;
            FILT_SEL_16: ratio = 5'd16;
            default:     ratio = 5'd1;
        endcase
        return ratio;
    endfunction

endpackage

// File: rtl/filt_decimator_if.sv
// -----------------------------------------------------------------------------
// filt_decimator_if
// Sample-stream bundle around the decimator: the upstream sample strobe/data
// and the downstream valid/ready output.
//   in_valid  : upstream sample strobe
//   in_data   : averaged sample from the filter
//   out_valid : decimated FIFO head is valid
//   out_ready : consumer accepts the head this cycle
//   out_data  : FIFO head sample
// Modports:
//   master : the environment (drives samples, consumes output)
//   slave  : the decimator
// -----------------------------------------------------------------------------
interface filt_decimator_if #(
    parameter int BIT_WIDTH = 16
);
    logic                 in_valid;
    logic [BIT_WIDTH-1:0] in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [BIT_WIDTH-1:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO without fall-through. The head sample is held in a
// register, so a push into an empty FIFO is visible on the next cycle and the
// head stays stable while not popped.
// Ports:
//   clk, sclr   : clock, synchronous active-high clear
//   i_push      : write i_data (caller guarantees room, or a pop in the cycle)
//   i_data      : sample to write
//   i_pop_req   : consumer ready; pops only when the FIFO holds data
//   o_valid     : FIFO not empty
//   o_data      : head sample
//   o_level     : occupancy 0..FIFO_DEPTH
//   o_full      : occupancy == FIFO_DEPTH
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int BIT_WIDTH  = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          sclr,
    input  logic                          i_push,
    input  logic [BIT_WIDTH-1:0]          i_data,
    input  logic                          i_pop_req,
    output logic                          o_valid,
    output logic [BIT_WIDTH-1:0]          o_data,
    output logic [$clog2(FIFO_DEPTH):0]   o_level,
    output logic                          o_full
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    logic [BIT_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [LW-1:0]        r_level;
    logic [BIT_WIDTH-1:0] r_head;

    logic          w_pop;
    logic [AW-1:0] w_rd_next;

    assign w_pop     = i_pop_req && (r_level != '0);
    assign w_rd_next = r_rd_ptr + 1'b1;

    // Storage array, no reset so it maps onto RAM
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (sclr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_head   <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_next;
            end
            case ({i_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            // The next head comes from RAM unless the FIFO is (or becomes)
            // empty, in which case the sample being written is the new head.
            // When full, push+pop writes the old head slot, which is never
            // the next head, so the RAM read is still correct.
            if (w_pop) begin
                if (r_level == LW'(1)) begin
                    if (i_push) begin
                        r_head <= i_data;
                    end
                end else begin
                    r_head <= r_mem[w_rd_next];
                end
            end else if ((r_level == '0) && i_push) begin
                r_head <= i_data;
            end
        end
    end

    assign o_valid = (r_level != '0);
    assign o_data  = r_head;
    assign o_level = r_level;
    assign o_full  = (r_level == LW'(FIFO_DEPTH));

endmodule

// File: rtl/filt_decimator.sv
// -----------------------------------------------------------------------------
// filt_decimator
// Decimates the box-car filter output by the filter length selected with
// filt_sel (1, 2, 4, 8, 16; codes 5..7 keep every sample), blanks a settling
// window after reset or a filt_sel change, buffers decimated samples in a
// FIFO and presents them on a valid/ready interface.
// Ports:
//   clk        : clock
//   sclr       : synchronous active-high reset
//   filt_sel   : filter-length code
//   io         : filt_decimator_if.slave (in_valid/in_data, out_valid/
//                out_ready/out_data)
//   fifo_level : FIFO occupancy
//   overflow   : sticky, a decimated sample was dropped on a full FIFO
//   ovf_count  : dropped-sample count, saturating at 255 (only when
//                FILT_DECIMATOR_OVF_CNT_EN is defined)
// Optional feature macro: FILT_DECIMATOR_OVF_CNT_EN
// -----------------------------------------------------------------------------
module filt_decimator
    import filt_pkg::*;
#(
    parameter int BIT_WIDTH    = 16,
    parameter int FIFO_DEPTH   = 8,
    parameter int FILT_LATENCY = 2
) (
    input  logic                        clk,
    input  logic                        sclr,
    input  logic [2:0]                  filt_sel,
    filt_decimator_if.slave             io,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overflow
`ifdef FILT_DECIMATOR_OVF_CNT_EN
    ,
    output logic [7:0]                  ovf_count
`endif
);
    localparam int CNT_W = $clog2(FILT_LATENCY + 1);

    filt_state_e      r_state;
    logic [CNT_W-1:0] r_settle_cnt;
    logic [3:0]       r_phase;
    logic [2:0]       r_sel_q;

    logic       w_sel_change;
    logic [4:0] w_ratio_m1;
    logic       w_phase_last;
    logic       w_push;
    logic       w_full;
    logic       w_fifo_valid;
    logic       w_pop;
    logic       w_push_ok;
    logic       w_drop;

    assign w_sel_change = (filt_sel != r_sel_q);
    assign w_ratio_m1   = filt_ratio(r_sel_q) - 5'd1;
    assign w_phase_last = ({1'b0, r_phase} == w_ratio_m1);

    // Push is decoded from the current state, not registered, so a kept
    // sample reaches the FIFO on the same edge it is presented.
    assign w_push = (r_state == RUN) && !w_sel_change && io.in_valid && w_phase_last;

    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign w_pop     = w_fifo_valid && io.out_ready;
    assign w_push_ok = w_push && (!w_full || w_pop);
    assign w_drop    = w_push && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (sclr) begin
            r_state      <= SETTLE;
            r_settle_cnt <= CNT_W'(FILT_LATENCY);
            r_phase      <= '0;
            r_sel_q      <= filt_sel;
        end else if (w_sel_change) begin
            // New filter length: upstream output is partial until it refills
            r_sel_q      <= filt_sel;
            r_state      <= SETTLE;
            r_settle_cnt <= CNT_W'(FILT_LATENCY);
            r_phase      <= '0;
        end else begin
            case (r_state)
                SETTLE: begin
                    if (r_settle_cnt == CNT_W'(1)) begin
                        r_state <= RUN;
                        r_phase <= '0;
                    end else begin
                        r_settle_cnt <= r_settle_cnt - 1'b1;
                    end
                end
                RUN: begin
                    if (io.in_valid) begin
                        r_phase <= w_phase_last ? 4'd0 : r_phase + 4'd1;
                    end
                end
            endcase
        end
    end

    sync_fifo #(
        .BIT_WIDTH  (BIT_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .sclr      (sclr),
        .i_push    (w_push_ok),
        .i_data    (io.in_data),
        .i_pop_req (io.out_ready),
        .o_valid   (w_fifo_valid),
        .o_data    (io.out_data),
        .o_level   (fifo_level),
        .o_full    (w_full)
    );

    assign io.out_valid = w_fifo_valid;

`ifdef FILT_DECIMATOR_OVF_CNT_EN
    logic [7:0] r_ovf_cnt;

    always_ff @(posedge clk) begin
        if (sclr) begin
            r_ovf_cnt <= '0;
        end else if (w_drop && (r_ovf_cnt != 8'hFF)) begin
            r_ovf_cnt <= r_ovf_cnt + 8'd1;
        end
    end

    assign ovf_count = r_ovf_cnt;
    assign overflow  = (r_ovf_cnt != 8'd0);
`else
    logic r_overflow;

    always_ff @(posedge clk) begin
        if (sclr) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    assign overflow = r_overflow;
`endif

endmodule
